// File: rtl/umi_initiator.sv
// Single-outstanding UMI request initiator: turns host read/write commands into UMI request
// packets and returns read data (or a timeout error) from write-posted responses.
module umi_initiator #(
  parameter int            AW      = 64,
  parameter int            DW      = 64,
  parameter int            UW      = 256,
  parameter logic [AW-1:0] SRCADDR = '0,
  parameter int            TIMEOUT = 1024,
  parameter int            TW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_req_valid,
  output logic          host_req_ready,
  input  logic          host_write,
  input  logic [AW-1:0] host_addr,
  input  logic [3:0]    host_size,
  input  logic [19:0]   host_options,
  input  logic [DW-1:0] host_wrdata,
  output logic          host_rsp_valid,
  output logic          host_rsp_error,
  output logic [DW-1:0] host_rsp_data,
  output logic          umi_req_out_valid,
  output logic [UW-1:0] umi_req_out_packet,
  input  logic          umi_req_out_ready,
  input  logic          umi_resp_in_valid,
  input  logic [UW-1:0] umi_resp_in_packet,
  output logic          umi_resp_in_ready
);

  // Packet layout (LSB first): command[6:0] (bit 0 is the write flag), burst, size[3:0],
  // options[19:0], dstaddr, srcaddr, data filling the remaining upper bits.
  localparam int PDW = UW - 32 - 2*AW;
  localparam logic [6:0] UMI_WRITE_POSTED = 7'h01;
  localparam logic [6:0] UMI_READ_REQUEST = 7'h02;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic logic [UW-1:0] umi_pack(
    input logic [6:0]     command,
    input logic           burst,
    input logic [3:0]     size,
    input logic [19:0]    options,
    input logic [AW-1:0]  dstaddr,
    input logic [AW-1:0]  srcaddr,
    input logic [PDW-1:0] data
  );
    return {data, srcaddr, dstaddr, options, size, burst, command};
  endfunction

  function automatic void umi_unpack(
    input  logic [UW-1:0]  packet,
    output logic [31:0]    cmd,
    output logic [AW-1:0]  dstaddr,
    output logic [AW-1:0]  srcaddr,
    output logic [PDW-1:0] data
  );
    cmd     = packet[31:0];
    dstaddr = packet[32 +: AW];
    srcaddr = packet[32+AW +: AW];
    data    = packet[UW-1 -: PDW];
  endfunction

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] data_q, data_d;

  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    size_q;
  logic [19:0]   opts_q;
  logic [DW-1:0] wrdata_q;

  logic [31:0]    rsp_cmd;
  logic [AW-1:0]  rsp_dst;
  logic [AW-1:0]  rsp_src;
  logic [PDW-1:0] rsp_data;
  logic           unused_rsp;

  always_comb begin
    umi_unpack(umi_resp_in_packet, rsp_cmd, rsp_dst, rsp_src, rsp_data);
  end

  assign unused_rsp = ^{rsp_cmd, rsp_src, rsp_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (host_req_valid) state_d = SEND;
      SEND: begin
        if (umi_req_out_ready) begin
          if (wr_q) begin
            state_d = DONE;
            err_d   = 1'b0;
            data_d  = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        // A matching response beats a timeout landing in the same cycle.
        if (umi_resp_in_valid && (rsp_dst == SRCADDR)) begin
          state_d = DONE;
          err_d   = 1'b0;
          data_d  = rsp_data[DW-1:0];
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = DONE;
          err_d   = 1'b1;
          data_d  = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
        data_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Command fields only load on accept, so the packet stays stable while SEND is stalled.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && host_req_valid) begin
      wr_q     <= host_write;
      addr_q   <= host_addr;
      size_q   <= host_size;
      opts_q   <= host_options;
      wrdata_q <= host_wrdata;
    end
  end

  assign umi_req_out_packet = umi_pack(wr_q ? UMI_WRITE_POSTED : UMI_READ_REQUEST, 1'b0,
                                       size_q, opts_q, addr_q, SRCADDR,
                                       wr_q ? PDW'(wrdata_q) : '0);

  assign host_req_ready    = (state_q == IDLE);
  assign umi_req_out_valid = (state_q == SEND);
  assign host_rsp_valid    = (state_q == DONE);
  assign host_rsp_error    = err_q;
  assign host_rsp_data     = data_q;
  assign umi_resp_in_ready = 1'b1;

endmodule

// File: tb/tb_umi_initiator.sv
// Directed bench for umi_initiator: request packets and completions are checked against
// scoreboard queues filled when the stimulus is driven.
module tb_umi_initiator;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int UW = 256;
  localparam int TO = 16;
  localparam logic [AW-1:0] SRC = 64'h100;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_req_valid;
  logic          host_req_ready;
  logic          host_write;
  logic [AW-1:0] host_addr;
  logic [3:0]    host_size;
  logic [19:0]   host_options;
  logic [DW-1:0] host_wrdata;
  logic          host_rsp_valid;
  logic          host_rsp_error;
  logic [DW-1:0] host_rsp_data;
  logic          umi_req_out_valid;
  logic [UW-1:0] umi_req_out_packet;
  logic          umi_req_out_ready;
  logic          umi_resp_in_valid;
  logic [UW-1:0] umi_resp_in_packet;
  logic          umi_resp_in_ready;

  umi_initiator #(.AW(AW), .DW(DW), .UW(UW), .SRCADDR(SRC), .TIMEOUT(TO), .TW(16)) dut (
    .clk(clk), .reset(reset),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_write(host_write), .host_addr(host_addr), .host_size(host_size),
    .host_options(host_options), .host_wrdata(host_wrdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_error(host_rsp_error),
    .host_rsp_data(host_rsp_data),
    .umi_req_out_valid(umi_req_out_valid), .umi_req_out_packet(umi_req_out_packet),
    .umi_req_out_ready(umi_req_out_ready),
    .umi_resp_in_valid(umi_resp_in_valid), .umi_resp_in_packet(umi_resp_in_packet),
    .umi_resp_in_ready(umi_resp_in_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rsp_q[$];
  logic [UW-1:0] pkt_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [UW-1:0] exp_req(input logic wr, input logic [AW-1:0] addr,
                                            input logic [3:0] size, input logic [19:0] opts,
                                            input logic [DW-1:0] data);
    logic [UW-1:0] p;
    p          = '0;
    p[6:0]     = wr ? 7'h01 : 7'h02;
    p[7]       = 1'b0;
    p[11:8]    = size;
    p[31:12]   = opts;
    p[95:32]   = addr;
    p[159:96]  = SRC;
    p[223:160] = wr ? data : 64'h0;
    return p;
  endfunction

  function automatic logic [UW-1:0] mk_rsp(input logic [AW-1:0] dst, input logic [DW-1:0] data);
    logic [UW-1:0] p;
    p          = '0;
    p[6:0]     = 7'h01;
    p[11:8]    = 4'd3;
    p[95:32]   = dst;
    p[159:96]  = 64'hABC0;
    p[223:160] = data;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [3:0] size,
                       input logic [19:0] opts, input logic [DW-1:0] data);
    rsp_t e;
    chk1("req_ready_idle", host_req_ready, 1'b1);
    host_req_valid = 1'b1;
    host_write     = wr;
    host_addr      = addr;
    host_size      = size;
    host_options   = opts;
    host_wrdata    = data;
    pkt_q.push_back(exp_req(wr, addr, size, opts, data));
    if (wr) begin
      e.err  = 1'b0;
      e.data = '0;
      rsp_q.push_back(e);
    end
    tick();
    host_req_valid = 1'b0;
    host_addr      = '1;
    host_wrdata    = '1;
    host_size      = 4'hF;
    host_options   = '1;
  endtask

  task automatic check_req(input string tag);
    logic [UW-1:0] p;
    p = pkt_q.pop_front();
    chk1({tag, "_valid"}, umi_req_out_valid, 1'b1);
    chk1({tag, "_hready"}, host_req_ready, 1'b0);
    chkw({tag, "_pkt"}, umi_req_out_packet, p);
  endtask

  task automatic push_rsp(input logic err, input logic [DW-1:0] data);
    rsp_t e;
    e.err  = err;
    e.data = data;
    rsp_q.push_back(e);
  endtask

  task automatic expect_rsp(input string tag);
    rsp_t e;
    e = rsp_q.pop_front();
    chk1({tag, "_valid"}, host_rsp_valid, 1'b1);
    chk1({tag, "_err"}, host_rsp_error, e.err);
    chkw({tag, "_data"}, UW'(host_rsp_data), UW'(e.data));
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n;
    n = 0;
    while (!host_rsp_valid && n < budget) begin
      tick();
      n++;
    end
    expect_rsp(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk1({tag, "_hready"}, host_req_ready, 1'b1);
    chk1({tag, "_rvalid"}, host_rsp_valid, 1'b0);
    chk1({tag, "_rerr"}, host_rsp_error, 1'b0);
    chkw({tag, "_rdata"}, UW'(host_rsp_data), '0);
    chk1({tag, "_qvalid"}, umi_req_out_valid, 1'b0);
    chk1({tag, "_pready"}, umi_resp_in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    host_req_valid     = 1'b0;
    host_write         = 1'b0;
    host_addr          = '0;
    host_size          = '0;
    host_options       = '0;
    host_wrdata        = '0;
    umi_req_out_ready  = 1'b1;
    umi_resp_in_valid  = 1'b0;
    umi_resp_in_packet = '0;
    tick();
    tick();
    check_idle_outputs("rst");
    reset = 1'b0;
    tick();

    // Posted write: completion two cycles after accept.
    issue(1'b1, 64'h1000, 4'd2, 20'h0, 64'hDEADBEEF);
    check_req("wr");
    tick();
    expect_rsp("wr_rsp");
    chk1("wr_done_qvalid", umi_req_out_valid, 1'b0);
    chk1("wr_done_hready", host_req_ready, 1'b0);
    tick();
    chk1("wr_after_rvalid", host_rsp_valid, 1'b0);
    chk1("wr_after_hready", host_req_ready, 1'b1);

    // Read answered after five WAIT cycles.
    issue(1'b0, 64'h2000, 4'd3, 20'h5, 64'h0);
    check_req("rd");
    tick();
    repeat (5) tick();
    chk1("rd_wait_rvalid", host_rsp_valid, 1'b0);
    chk1("rd_wait_pready", umi_resp_in_ready, 1'b1);
    umi_resp_in_valid  = 1'b1;
    umi_resp_in_packet = mk_rsp(SRC, 64'h1234);
    push_rsp(1'b0, 64'h1234);
    tick();
    umi_resp_in_valid = 1'b0;
    expect_rsp("rd_rsp");
    tick();
    chk1("rd_pulse_end", host_rsp_valid, 1'b0);

    // Downstream stall for ten cycles during a write.
    umi_req_out_ready = 1'b0;
    issue(1'b1, 64'h3000, 4'd3, 20'hABCDE, 64'hCAFEF00D12345678);
    for (int i = 0; i < 10; i++) begin
      chk1("hold_valid", umi_req_out_valid, 1'b1);
      chkw("hold_pkt", umi_req_out_packet, pkt_q[0]);
      chk1("hold_rvalid", host_rsp_valid, 1'b0);
      tick();
    end
    check_req("hold");
    umi_req_out_ready = 1'b1;
    tick();
    expect_rsp("hold_rsp");
    tick();
    chk1("hold_single", host_rsp_valid, 1'b0);

    // Non-matching response is dropped, the matching one completes the read.
    issue(1'b0, 64'h4000, 4'd2, 20'h1, 64'h0);
    check_req("nm");
    tick();
    umi_resp_in_valid  = 1'b1;
    umi_resp_in_packet = mk_rsp(SRC + 64'd8, 64'hBAD);
    tick();
    chk1("nm_drop_rvalid", host_rsp_valid, 1'b0);
    chk1("nm_drop_hready", host_req_ready, 1'b0);
    chk1("nm_drop_pready", umi_resp_in_ready, 1'b1);
    umi_resp_in_packet = mk_rsp(SRC, 64'h5678);
    push_rsp(1'b0, 64'h5678);
    tick();
    umi_resp_in_valid = 1'b0;
    expect_rsp("nm_rsp");
    tick();

    // Timeout: error completion exactly TO cycles after entering WAIT.
    issue(1'b0, 64'h5000, 4'd3, 20'h0, 64'h0);
    check_req("to");
    tick();
    push_rsp(1'b1, 64'h0);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk1("to_wait_rvalid", host_rsp_valid, 1'b0);
    end
    tick();
    expect_rsp("to_rsp");
    tick();
    umi_resp_in_valid  = 1'b1;
    umi_resp_in_packet = mk_rsp(SRC, 64'h77);
    tick();
    umi_resp_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1("to_stray_rvalid", host_rsp_valid, 1'b0);
      tick();
    end

    // Matching response on the timeout threshold cycle wins.
    issue(1'b0, 64'h5800, 4'd3, 20'h0, 64'h0);
    check_req("thr");
    tick();
    repeat (TO - 1) tick();
    chk1("thr_pre_rvalid", host_rsp_valid, 1'b0);
    umi_resp_in_valid  = 1'b1;
    umi_resp_in_packet = mk_rsp(SRC, 64'h9ABC);
    push_rsp(1'b0, 64'h9ABC);
    tick();
    umi_resp_in_valid = 1'b0;
    expect_rsp("thr_rsp");
    tick();

    // Reset in WAIT abandons the read; a late response is dropped.
    issue(1'b0, 64'h6000, 4'd3, 20'h0, 64'h0);
    check_req("rw");
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_idle_outputs("rw_async");
    tick();
    reset = 1'b0;
    chk1("rw_rel_hready", host_req_ready, 1'b1);
    umi_resp_in_valid  = 1'b1;
    umi_resp_in_packet = mk_rsp(SRC, 64'hDEAD);
    tick();
    umi_resp_in_valid = 1'b0;
    chk1("rw_late_rvalid", host_rsp_valid, 1'b0);
    tick();
    chk1("rw_late_rvalid2", host_rsp_valid, 1'b0);
    issue(1'b0, 64'h7000, 4'd2, 20'h3, 64'h0);
    check_req("rw_rd");
    tick();
    tick();
    umi_resp_in_valid  = 1'b1;
    umi_resp_in_packet = mk_rsp(SRC, 64'h4242);
    push_rsp(1'b0, 64'h4242);
    tick();
    umi_resp_in_valid = 1'b0;
    wait_rsp("rw_rsp", 20);
    tick();

    chk1("sb_rsp_empty", rsp_q.size() == 0, 1'b1);
    chk1("sb_pkt_empty", pkt_q.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
